// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory port arbiter: access size
// encodings, requester identifiers and the arbiter FSM state type.
package mem_arb_pkg;

  // d_size encodings; 2'b11 is reserved and treated as an error
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Requester identifiers used for ownership and round-robin history
  typedef enum logic {
    REQ_F = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  // Arbiter / access sequencing states
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    ACCESS   = 2'b01,
    MERGE_WR = 2'b10,
    RESP     = 2'b11
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane helper for the memory port: detects misaligned sizes, merges
// sub-word store data into a full read word, and extracts/extends loads.
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        misaligned,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_sh = {addr_lo, 3'b000};
  assign half_sh = {addr_lo[1], 4'b0000};
  assign byte_v  = rword[byte_sh +: 8];
  assign half_v  = rword[half_sh +: 16];

  // Per-size alignment check, store lane merge and load formatting
  always_comb begin
    misaligned = 1'b0;
    merged     = rword;
    load_data  = '0;
    case (size)
      SZ_B: begin
        merged[byte_sh +: 8] = wdata[7:0];
        load_data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
      end
      SZ_H: begin
        misaligned = addr_lo[0];
        merged[half_sh +: 16] = wdata[15:0];
        load_data = {{16{~is_unsigned & half_v[15]}}, half_v};
      end
      SZ_W: begin
        misaligned = |addr_lo;
        merged     = wdata;
        load_data  = rword;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one unified memory port between instruction
// fetch and load/store. Sub-word stores are done as read-modify-write since
// the memory only writes full 32-bit words.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_BYTES = 262144
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ready,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  state_t            state;
  req_id_t           last_grant;
  req_id_t           owner;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rword_q;
  logic              err_q;
  logic [ADDR_W-1:0] mem_addr_q;

  logic              grant_f;
  logic              grant_d;
  logic              in_idle;
  logic              resp_v;
  logic              misaligned;
  logic              out_of_range;
  logic              acc_err;
  logic [31:0]       merged;
  logic [31:0]       load_data;
  logic [31:0]       rdata_fmt;
  logic [ADDR_W:0]   base_ext;

  mem_lane_align u_align (
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rword       (rword_q),
    .misaligned  (misaligned),
    .merged      (merged),
    .load_data   (load_data)
  );

  // Error is evaluated from the latched request during ACCESS; the latched
  // fields are fixed from accept onwards, so this equals an accept-time check.
  always_comb begin
    base_ext     = {1'b0, addr_q[ADDR_W-1:2], 2'b00};
    out_of_range = (base_ext + (ADDR_W+1)'(3)) >= (ADDR_W+1)'(MEM_BYTES);
    acc_err      = misaligned | out_of_range;
  end

  // Round-robin arbitration; fetch wins a tie unless it was granted last
  always_comb begin
    grant_f = f_req & (~d_req | (last_grant == REQ_D));
    grant_d = d_req & ~grant_f;
    in_idle = (state == IDLE) & ~reset;
    f_ready = in_idle & grant_f;
    d_ready = in_idle & grant_d;
  end

  // Memory-side drive; reset gates the write so an aborted RMW never lands
  always_comb begin
    mem_addr  = mem_addr_q;
    mem_we    = ~reset & (((state == ACCESS) & we_q & ~acc_err & (size_q == SZ_W))
                          | (state == MERGE_WR));
    mem_wdata = mem_we ? merged : '0;
  end

  // Response strobe and formatted data for the current owner
  always_comb begin
    resp_v    = ~reset & (state == RESP);
    rdata_fmt = (err_q | we_q) ? '0 : load_data;
    f_rvalid  = resp_v & (owner == REQ_F);
    d_rvalid  = resp_v & (owner == REQ_D);
    f_rdata   = f_rvalid ? rdata_fmt : '0;
    d_rdata   = d_rvalid ? rdata_fmt : '0;
    f_err     = f_rvalid & err_q;
    d_err     = d_rvalid & err_q;
  end

  // Arbiter FSM: accept, access memory, optional merge write, respond
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= REQ_D;
      owner      <= REQ_F;
      addr_q     <= '0;
      we_q       <= 1'b0;
      size_q     <= SZ_B;
      uns_q      <= 1'b0;
      wdata_q    <= '0;
      rword_q    <= '0;
      err_q      <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_f) begin
            owner      <= REQ_F;
            last_grant <= REQ_F;
            addr_q     <= f_addr;
            we_q       <= 1'b0;
            size_q     <= SZ_W;
            uns_q      <= 1'b0;
            wdata_q    <= '0;
            mem_addr_q <= {f_addr[ADDR_W-1:2], 2'b00};
            state      <= ACCESS;
          end else if (grant_d) begin
            owner      <= REQ_D;
            last_grant <= REQ_D;
            addr_q     <= d_addr;
            we_q       <= d_we;
            size_q     <= d_size;
            uns_q      <= d_unsigned;
            wdata_q    <= d_wdata;
            mem_addr_q <= {d_addr[ADDR_W-1:2], 2'b00};
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          err_q <= acc_err;
          if (acc_err) begin
            state <= RESP;
          end else if (!we_q) begin
            rword_q <= mem_rdata;
            state   <= RESP;
          end else if (size_q == SZ_W) begin
            state <= RESP;
          end else begin
            rword_q <= mem_rdata;
            state   <= MERGE_WR;
          end
        end
        MERGE_WR: begin
          state <= RESP;
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single accesses
// plus hand-written sequences for arbitration ties and reset mid-RMW.
module tb_mem_port_arbiter;

  typedef struct {
    logic        is_f;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_wcnt;
    int          exp_wrel;
    logic [31:0] exp_wdat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_ready, f_rvalid, f_err;
  logic [31:0] f_rdata;
  logic        d_req, d_we, d_unsigned;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata;
  logic        d_ready, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] mem [0:1023];
  logic        mem_init;
  int          we_total = 0;

  int total = 0;
  int bad   = 0;

  // run_one results
  logic [31:0] r_rd, r_wdat;
  logic        r_err;
  int          r_lat, r_wcnt, r_wrel, r_xrv;

  // tie_run results
  int          fa[4], da[4], fr[4], dr[4];
  int          nfa, nda, nfr, ndr, both_ready;
  logic [31:0] d_rd_tie;

  vec_t vecs[$];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .MEM_BYTES(262144)) dut (
    .clk        (clk),
    .reset      (reset),
    .f_req      (f_req),
    .f_addr     (f_addr),
    .f_ready    (f_ready),
    .f_rvalid   (f_rvalid),
    .f_rdata    (f_rdata),
    .f_err      (f_err),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_size     (d_size),
    .d_unsigned (d_unsigned),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ready    (d_ready),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .d_err      (d_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  // Memory model: combinational read, synchronous full-word write
  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[21]   <= 32'h02800113;
      mem[256]  <= 32'h11223344;
      mem[257]  <= 32'h80F6A000;
      mem[259]  <= 32'h0A0B0C0D;
      mem[1023] <= 32'hCAFEF00D;
    end else if (mem_we === 1'b1) begin
      mem[mem_addr[11:2]] <= mem_wdata;
    end
  end

  always @(posedge clk) if (mem_we === 1'b1) we_total <= we_total + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic is_f, input logic we, input logic [1:0] size,
                              input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rd, input logic exp_err, input int exp_lat,
                              input int exp_wcnt, input int exp_wrel, input logic [31:0] exp_wdat);
    vec_t v;
    v.is_f = is_f; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rd = exp_rd; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_wcnt = exp_wcnt; v.exp_wrel = exp_wrel; v.exp_wdat = exp_wdat;
    return v;
  endfunction

  // One request through the port; starts and ends at posedge+1
  task automatic run_one(input vec_t v);
    int acc;
    int rv;
    acc = -1; rv = -1;
    r_rd = '0; r_err = 1'b0; r_wcnt = 0; r_wrel = -1; r_wdat = '0; r_xrv = 0;
    if (v.is_f) begin
      f_req = 1'b1; f_addr = v.addr;
    end else begin
      d_req = 1'b1; d_we = v.we; d_size = v.size; d_unsigned = v.uns;
      d_addr = v.addr; d_wdata = v.wdata;
    end
    for (int cyc = 0; cyc < 20 && rv < 0; cyc++) begin
      @(negedge clk);
      if (acc < 0 && (v.is_f ? f_ready : d_ready)) acc = cyc;
      if (mem_we) begin
        r_wcnt++; r_wrel = cyc - acc; r_wdat = mem_wdata;
      end
      if (v.is_f ? f_rvalid : d_rvalid) begin
        rv = cyc;
        r_rd  = v.is_f ? f_rdata : d_rdata;
        r_err = v.is_f ? f_err : d_err;
      end
      if (v.is_f ? d_rvalid : f_rvalid) r_xrv++;
      @(posedge clk); #1;
      if (acc == cyc) begin
        f_req = 1'b0; d_req = 1'b0;
      end
    end
    f_req = 1'b0; d_req = 1'b0;
    r_lat = (rv < 0 || acc < 0) ? -1 : rv - acc;
  endtask

  // Fetch (addr 0) and data load (0x400) requesting together; fetch re-requests
  // until nf accepts so back-to-back ties can be observed
  task automatic tie_run(input int nf, input int nd);
    for (int i = 0; i < 4; i++) begin
      fa[i] = -1; da[i] = -1; fr[i] = -1; dr[i] = -1;
    end
    nfa = 0; nda = 0; nfr = 0; ndr = 0; both_ready = 0; d_rd_tie = '0;
    f_addr = 32'h0; d_addr = 32'h400; d_we = 1'b0; d_size = 2'b10;
    d_unsigned = 1'b0; d_wdata = '0;
    f_req = (nf > 0); d_req = (nd > 0);
    for (int cyc = 0; cyc < 40 && (nfr < nf || ndr < nd); cyc++) begin
      logic fa_now, da_now;
      @(negedge clk);
      fa_now = f_ready; da_now = d_ready;
      if (fa_now && da_now) both_ready++;
      if (fa_now && nfa < 4) begin fa[nfa] = cyc; nfa++; end
      if (da_now && nda < 4) begin da[nda] = cyc; nda++; end
      if (f_rvalid && nfr < 4) begin fr[nfr] = cyc; nfr++; end
      if (d_rvalid && ndr < 4) begin dr[ndr] = cyc; ndr++; d_rd_tie = d_rdata; end
      @(posedge clk); #1;
      if (fa_now && nfa >= nf) f_req = 1'b0;
      if (da_now && nda >= nd) d_req = 1'b0;
    end
    f_req = 1'b0; d_req = 1'b0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"}, {25'h0, f_ready, f_rvalid, f_err, d_ready, d_rvalid, d_err, mem_we}, '0);
    chk({tag, "_frd"}, f_rdata, '0);
    chk({tag, "_drd"}, d_rdata, '0);
    chk({tag, "_maddr"}, mem_addr, '0);
    chk({tag, "_mwd"}, mem_wdata, '0);
  endtask

  initial begin
    int quiet_bad;
    int we_snap;

    reset = 1'b1; mem_init = 1'b1;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_size = 2'b00; d_unsigned = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    chk_quiet("rst_hold");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk_quiet("rst_rel");
    @(posedge clk); #1;

    // Tie after reset: fetch first, then data, then fetch again
    tie_run(2, 1);
    chk("tie_f_acc0", fa[0], 0);
    chk("tie_f_rv0", fr[0], 2);
    chk("tie_d_acc", da[0], 3);
    chk("tie_d_rv", dr[0], 5);
    chk("tie_f_acc1", fa[1], 6);
    chk("tie_f_rv1", fr[1], 8);
    chk("tie_both_ready", both_ready, 0);
    chk("tie_d_rdata", d_rd_tie, 32'h11223344);

    //                is_f  we    size   uns   addr          wdata         exp_rd        err   lat wc wrel wdat
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h00000054, 32'h0,        32'h02800113, 1'b0, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b00, 1'b0, 32'h00000402, 32'h000000AB, 32'h0,        1'b0, 3, 1, 2, 32'h11AB3344));
    vecs.push_back(mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h00000400, 32'h0,        32'h11AB3344, 1'b0, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h00000407, 32'h0,        32'hFFFFFF80, 1'b0, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b1, 32'h00000407, 32'h0,        32'h00000080, 1'b0, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 2'b01, 1'b0, 32'h00000406, 32'h0,        32'hFFFF80F6, 1'b0, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 2'b01, 1'b1, 32'h00000404, 32'h0,        32'h0000A000, 1'b0, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h00000405, 32'h0,        32'hFFFFFFA0, 1'b0, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h00000402, 32'h0,        32'h0,        1'b1, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h00000401, 32'h00001234, 32'h0,        1'b1, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1'b1, 1'b0, 2'b10, 1'b0, 32'h00000006, 32'h0,        32'h0,        1'b1, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 2'b11, 1'b0, 32'h00000400, 32'h0,        32'h0,        1'b1, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h00000408, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 1, 32'hDEADBEEF));
    vecs.push_back(mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h00000408, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b01, 1'b0, 32'h00000402, 32'hFFFF5678, 32'h0,        1'b0, 3, 1, 2, 32'h56783344));
    vecs.push_back(mk(1'b0, 1'b0, 2'b01, 1'b1, 32'h00000402, 32'h0,        32'h00005678, 1'b0, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 2'b01, 1'b0, 32'h00000400, 32'h0,        32'h00003344, 1'b0, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h0003FFFC, 32'h0,        32'hCAFEF00D, 1'b0, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 2'b00, 1'b0, 32'h0003FFFF, 32'h0,        32'hFFFFFFCA, 1'b0, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b0, 2'b10, 1'b0, 32'h00040000, 32'h0,        32'h0,        1'b1, 2, 0, 0, 32'h0));
    vecs.push_back(mk(1'b0, 1'b1, 2'b10, 1'b0, 32'h00040000, 32'h12345678, 32'h0,        1'b1, 2, 0, 0, 32'h0));

    foreach (vecs[i]) begin
      run_one(vecs[i]);
      chk($sformatf("v%0d_rdata", i), r_rd, vecs[i].exp_rd);
      chk($sformatf("v%0d_err", i), {31'h0, r_err}, {31'h0, vecs[i].exp_err});
      chk($sformatf("v%0d_lat", i), r_lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_wecnt", i), r_wcnt, vecs[i].exp_wcnt);
      chk($sformatf("v%0d_xrvalid", i), r_xrv, 0);
      if (vecs[i].exp_wcnt > 0) begin
        chk($sformatf("v%0d_wecyc", i), r_wrel, vecs[i].exp_wrel);
        chk($sformatf("v%0d_wedata", i), r_wdat, vecs[i].exp_wdat);
      end
    end

    // Reset while in MERGE_WR of an sb 0xEE to 0x40D
    d_req = 1'b1; d_we = 1'b1; d_size = 2'b00; d_unsigned = 1'b0;
    d_addr = 32'h40D; d_wdata = 32'h000000EE;
    @(negedge clk);
    chk("rmw_accept", {31'h0, d_ready}, 32'h1);
    @(posedge clk); #1 d_req = 1'b0;
    @(posedge clk); #1;
    chk("rmw_merge_we", {31'h0, mem_we}, 32'h1);
    chk("rmw_merge_wd", mem_wdata, 32'h0A0BEE0D);
    reset = 1'b1;
    #1;
    chk("rst_gate_we", {31'h0, mem_we}, 32'h0);
    we_snap = we_total;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    quiet_bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (f_rvalid || d_rvalid || mem_we) quiet_bad++;
    end
    chk("post_rst_quiet", quiet_bad, 0);
    chk("post_rst_we_total", we_total, we_snap);
    chk("post_rst_mem_keep", mem[259], 32'h0A0B0C0D);
    chk_quiet("post_rst");
    @(posedge clk); #1;

    // First tie after reset goes to fetch again
    tie_run(1, 1);
    chk("tie2_f_acc", fa[0], 0);
    chk("tie2_d_acc", da[0], 3);
    chk("tie2_d_rv", dr[0], 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
